// File: rtl/id_pkg.sv
// Shared decode constants for the ID stage: opcodes, control-bit layout and
// the opcode-to-control decoder.
package id_pkg;

    localparam int CTRL_W = 8;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam int C_REGDST   = 7;
    localparam int C_MEMREAD  = 6;
    localparam int C_MEMTOREG = 5;
    localparam int C_ALUOP_HI = 4;
    localparam int C_ALUOP_LO = 3;
    localparam int C_MEMWRITE = 2;
    localparam int C_ALUSRC   = 1;
    localparam int C_REGWRITE = 0;

    function automatic logic [CTRL_W-1:0] decode_ctrl(input logic [5:0] op);
        logic [CTRL_W-1:0] c;
        c = '0;
        unique case (op)
            OP_RTYPE: begin
                c[C_REGDST]   = 1'b1;
                c[C_ALUOP_HI] = 1'b1;
                c[C_REGWRITE] = 1'b1;
            end
            OP_LW: begin
                c[C_MEMREAD]  = 1'b1;
                c[C_MEMTOREG] = 1'b1;
                c[C_ALUSRC]   = 1'b1;
                c[C_REGWRITE] = 1'b1;
            end
            OP_SW: begin
                c[C_MEMWRITE] = 1'b1;
                c[C_ALUSRC]   = 1'b1;
            end
            OP_ADDI: begin
                c[C_ALUSRC]   = 1'b1;
                c[C_REGWRITE] = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                c[C_ALUOP_LO] = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/id_regfile.sv
// NREGS x XLEN register file: two async read ports, one write port,
// same-cycle write-to-read bypass, register 0 hardwired to zero.
module id_regfile
    import id_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int RA_W  = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_en,
    input  logic [RA_W-1:0] wr_addr,
    input  logic [XLEN-1:0] wr_data,
    input  logic [RA_W-1:0] addr_a,
    input  logic [RA_W-1:0] addr_b,
    output logic [XLEN-1:0] data_a,
    output logic [XLEN-1:0] data_b
);

    logic [XLEN-1:0] regs [NREGS];
    logic            wr_live;

    assign wr_live = wr_en && (wr_addr != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_live) begin
            regs[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        data_a = regs[addr_a];
        data_b = regs[addr_b];
        if (wr_live && wr_addr == addr_a) data_a = wr_data;
        if (wr_live && wr_addr == addr_b) data_b = wr_data;
        if (addr_a == '0) data_a = '0;
        if (addr_b == '0) data_b = '0;
    end

endmodule

// File: rtl/id_stage_param.sv
// Parametrised decode stage: decode, regfile read with forwarding, branch
// resolution, hazard stall counter and a registered ID/EX bundle.
module id_stage_param
    import id_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int NREGS   = 32,
    localparam int RA_W   = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_valid,
    input  logic [31:0]       if_instr,
    input  logic [31:0]       if_pc4,
    output logic              id_ready,
    input  logic              flush,
    input  logic              ex_ready,
    input  logic              exmem_regwrite,
    input  logic [RA_W-1:0]   exmem_rd,
    input  logic [XLEN-1:0]   exmem_result,
    input  logic              memwb_regwrite,
    input  logic [RA_W-1:0]   memwb_rd,
    input  logic [XLEN-1:0]   memwb_data,
    output logic              br_taken,
    output logic [31:0]       br_target,
    output logic              idex_valid,
    output logic [CTRL_W-1:0] idex_ctrl,
    output logic [XLEN-1:0]   idex_rs_val,
    output logic [XLEN-1:0]   idex_rt_val,
    output logic [XLEN-1:0]   idex_imm,
    output logic [RA_W-1:0]   idex_rs,
    output logic [RA_W-1:0]   idex_rt,
    output logic [RA_W-1:0]   idex_rd,
    output logic [31:0]       idex_pc4
);

    logic [5:0]        opcode;
    logic [RA_W-1:0]   rs, rt, rd;
    logic [15:0]       imm16;
    logic [XLEN-1:0]   imm;
    logic [CTRL_W-1:0] ctrl;
    logic              is_beq, is_bne, is_j, is_br;
    logic              use_rs, use_rt;

    assign opcode = if_instr[31:26];
    assign rs     = if_instr[21 +: RA_W];
    assign rt     = if_instr[16 +: RA_W];
    assign rd     = if_instr[11 +: RA_W];
    assign imm16  = if_instr[15:0];
    assign imm    = {{(XLEN-16){imm16[15]}}, imm16};
    assign ctrl   = decode_ctrl(opcode);

    assign is_beq = (opcode == OP_BEQ);
    assign is_bne = (opcode == OP_BNE);
    assign is_j   = (opcode == OP_J);
    assign is_br  = is_beq || is_bne;

    // rt is a destination for lw/addi, so it only counts as a source here
    assign use_rt = (opcode == OP_RTYPE) || (opcode == OP_SW) || is_br;
    assign use_rs = use_rt || (opcode == OP_LW) || (opcode == OP_ADDI);

    logic [XLEN-1:0] rf_a, rf_b;

    id_regfile #(
        .XLEN  (XLEN),
        .NREGS (NREGS),
        .RA_W  (RA_W)
    ) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (memwb_regwrite),
        .wr_addr (memwb_rd),
        .wr_data (memwb_data),
        .addr_a  (rs),
        .addr_b  (rt),
        .data_a  (rf_a),
        .data_b  (rf_b)
    );

    function automatic logic [XLEN-1:0] fwd(
        input logic [RA_W-1:0] src,
        input logic [XLEN-1:0] rf_val
    );
        if (exmem_regwrite && exmem_rd == src && src != '0)
            return exmem_result;
        else if (memwb_regwrite && memwb_rd == src && src != '0)
            return memwb_data;
        else
            return rf_val;
    endfunction

    logic [XLEN-1:0] rs_val, rt_val;
    logic            eq;

    assign rs_val = fwd(rs, rf_a);
    assign rt_val = fwd(rt, rf_b);
    assign eq     = (rs_val == rt_val);

    logic [RA_W-1:0] idex_dest;
    logic            ld_match, alu_match;
    logic            hz_any, hz_long;
    logic [1:0]      stall_cnt, cnt_next;
    logic            stall;

    assign idex_dest = idex_ctrl[C_REGDST] ? idex_rd : idex_rt;

    assign ld_match = idex_valid && idex_ctrl[C_MEMREAD] &&
                      idex_rt != '0 &&
                      ((use_rs && idex_rt == rs) ||
                       (use_rt && idex_rt == rt));

    assign alu_match = idex_valid && idex_ctrl[C_REGWRITE] &&
                       !idex_ctrl[C_MEMREAD] && idex_dest != '0 &&
                       (idex_dest == rs || idex_dest == rt);

    // The detection cycle is itself a stall cycle; the counter holds the rest
    assign hz_any  = if_valid && (ld_match || (is_br && alu_match));
    assign hz_long = if_valid && is_br && ld_match;

    assign stall    = (stall_cnt != 2'd0) || hz_any;
    assign cnt_next = (stall_cnt != 2'd0) ? stall_cnt - 2'd1 :
                      (hz_long ? 2'd1 : 2'd0);

    assign id_ready = ex_ready && !stall;

    always_comb begin
        br_target = if_pc4 + {{14{imm16[15]}}, imm16, 2'b00};
        if (is_j) br_target = {if_pc4[31:28], if_instr[25:0], 2'b00};
    end

    assign br_taken = !rst && if_valid && !stall && ex_ready &&
                      (is_j || (is_beq && eq) || (is_bne && !eq));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt   <= 2'd0;
            idex_valid  <= 1'b0;
            idex_ctrl   <= '0;
            idex_rs_val <= '0;
            idex_rt_val <= '0;
            idex_imm    <= '0;
            idex_rs     <= '0;
            idex_rt     <= '0;
            idex_rd     <= '0;
            idex_pc4    <= '0;
        end else if (flush) begin
            stall_cnt  <= 2'd0;
            idex_valid <= 1'b0;
            idex_ctrl  <= '0;
        end else if (ex_ready) begin
            stall_cnt <= cnt_next;
            if (stall || !if_valid) begin
                idex_valid <= 1'b0;
                idex_ctrl  <= '0;
            end else begin
                idex_valid  <= 1'b1;
                idex_ctrl   <= ctrl;
                idex_rs_val <= rs_val;
                idex_rt_val <= rt_val;
                idex_imm    <= imm;
                idex_rs     <= rs;
                idex_rt     <= rt;
                idex_rd     <= rd;
                idex_pc4    <= if_pc4;
            end
        end
    end

endmodule

// File: tb/tb_id_stage_param.sv
// Directed bench for id_stage_param: decode, forwarding, hazards,
// branches, handshake hold, flush and reset.
module tb_id_stage_param;

    localparam int XLEN = 32;
    localparam int RA_W = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic            if_valid;
    logic [31:0]     if_instr;
    logic [31:0]     if_pc4;
    logic            id_ready;
    logic            flush;
    logic            ex_ready;
    logic            exmem_regwrite;
    logic [RA_W-1:0] exmem_rd;
    logic [XLEN-1:0] exmem_result;
    logic            memwb_regwrite;
    logic [RA_W-1:0] memwb_rd;
    logic [XLEN-1:0] memwb_data;
    logic            br_taken;
    logic [31:0]     br_target;
    logic            idex_valid;
    logic [7:0]      idex_ctrl;
    logic [XLEN-1:0] idex_rs_val, idex_rt_val, idex_imm;
    logic [RA_W-1:0] idex_rs, idex_rt, idex_rd;
    logic [31:0]     idex_pc4;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    id_stage_param #(.XLEN(XLEN), .NREGS(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc4         (if_pc4),
        .id_ready       (id_ready),
        .flush          (flush),
        .ex_ready       (ex_ready),
        .exmem_regwrite (exmem_regwrite),
        .exmem_rd       (exmem_rd),
        .exmem_result   (exmem_result),
        .memwb_regwrite (memwb_regwrite),
        .memwb_rd       (memwb_rd),
        .memwb_data     (memwb_data),
        .br_taken       (br_taken),
        .br_target      (br_target),
        .idex_valid     (idex_valid),
        .idex_ctrl      (idex_ctrl),
        .idex_rs_val    (idex_rs_val),
        .idex_rt_val    (idex_rt_val),
        .idex_imm       (idex_imm),
        .idex_rs        (idex_rs),
        .idex_rt        (idex_rt),
        .idex_rd        (idex_rd),
        .idex_pc4       (idex_pc4)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] r_ins(input logic [4:0] s,
                                          input logic [4:0] t,
                                          input logic [4:0] d);
        return {6'h00, s, t, d, 11'h020};
    endfunction

    function automatic logic [31:0] i_ins(input logic [5:0] op,
                                          input logic [4:0] s,
                                          input logic [4:0] t,
                                          input logic [15:0] im);
        return {op, s, t, im};
    endfunction

    function automatic logic [31:0] j_ins(input logic [25:0] tgt);
        return {6'h02, tgt};
    endfunction

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        ex_ready = 1'b1;
        exmem_regwrite = 1'b0;
        exmem_rd = '0;
        exmem_result = '0;
        memwb_regwrite = 1'b0;
        memwb_rd = '0;
        memwb_data = '0;
        if_valid = 1'b1;
        if_instr = j_ins(26'h123);
        if_pc4 = 32'h100;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", idex_valid, 0);
        check("rst_ctrl", idex_ctrl, 0);
        check("rst_pc4", idex_pc4, 0);
        check("rst_brtaken", br_taken, 0);
        rst = 1'b0;
        if_valid = 1'b0;

        memwb_regwrite = 1'b1;
        memwb_rd = 5'd5;
        memwb_data = 32'h1234;
        tick();
        memwb_regwrite = 1'b0;
        if_valid = 1'b1;
        if_instr = r_ins(5, 0, 3);
        if_pc4 = 32'h40;
        #1;
        check("add_ready", id_ready, 1);
        tick();
        check("add_valid", idex_valid, 1);
        check("add_ctrl", idex_ctrl, 8'h91);
        check("add_rsval", idex_rs_val, 32'h1234);
        check("add_rtval", idex_rt_val, 0);
        check("add_rd", idex_rd, 3);
        check("add_pc4", idex_pc4, 32'h40);

        if_instr = i_ins(6'h23, 1, 2, 16'hFFFC);
        if_pc4 = 32'h44;
        #1;
        check("lw_ready", id_ready, 1);
        tick();
        check("lw_ctrl", idex_ctrl, 8'h63);
        check("lw_imm", idex_imm, 32'hFFFF_FFFC);
        check("lw_rt", idex_rt, 2);
        if_instr = r_ins(2, 2, 4);
        if_pc4 = 32'h48;
        #1;
        check("lu_stall", id_ready, 0);
        tick();
        check("lu_bubble_v", idex_valid, 0);
        check("lu_bubble_c", idex_ctrl, 0);
        exmem_regwrite = 1'b1;
        exmem_rd = 5'd2;
        exmem_result = 32'h55;
        #1;
        check("lu_ready", id_ready, 1);
        tick();
        check("lu_issue_v", idex_valid, 1);
        check("lu_rsval", idex_rs_val, 32'h55);
        check("lu_rtval", idex_rt_val, 32'h55);
        check("lu_rd", idex_rd, 4);
        exmem_regwrite = 1'b0;

        if_instr = i_ins(6'h04, 1, 1, 16'd3);
        if_pc4 = 32'h100;
        #1;
        check("beq_taken", br_taken, 1);
        check("beq_target", br_target, 32'h10C);
        if_instr = i_ins(6'h05, 1, 1, 16'd3);
        #1;
        check("bne_taken", br_taken, 0);
        check("bne_target", br_target, 32'h10C);
        if_instr = i_ins(6'h04, 0, 0, 16'hFFFF);
        #1;
        check("beqneg_tgt", br_target, 32'hFC);
        if_instr = j_ins(26'h123);
        if_pc4 = 32'h1000_0100;
        #1;
        check("j_taken", br_taken, 1);
        check("j_target", br_target, 32'h1000_048C);
        ex_ready = 1'b0;
        #1;
        check("j_exready0", br_taken, 0);
        ex_ready = 1'b1;
        if_valid = 1'b0;
        tick();
        check("ifv0_bubble", idex_valid, 0);

        if_valid = 1'b1;
        if_instr = i_ins(6'h23, 0, 7, 16'd0);
        if_pc4 = 32'h1FC;
        tick();
        if_instr = i_ins(6'h04, 7, 6, 16'd1);
        if_pc4 = 32'h200;
        #1;
        check("bl_ready0", id_ready, 0);
        check("bl_taken0", br_taken, 0);
        tick();
        check("bl_bubble", idex_valid, 0);
        check("bl_ready1", id_ready, 0);
        check("bl_taken1", br_taken, 0);
        tick();
        exmem_regwrite = 1'b1;
        exmem_rd = 5'd7;
        exmem_result = 32'hABCD;
        memwb_regwrite = 1'b1;
        memwb_rd = 5'd6;
        memwb_data = 32'hABCD;
        #1;
        check("bl_ready2", id_ready, 1);
        check("bl_taken", br_taken, 1);
        check("bl_target", br_target, 32'h204);
        tick();
        check("bl_issue_v", idex_valid, 1);
        check("bl_issue_c", idex_ctrl, 8'h08);
        check("bl_rsval", idex_rs_val, 32'hABCD);
        exmem_regwrite = 1'b0;
        memwb_regwrite = 1'b0;

        if_instr = i_ins(6'h08, 0, 9, 16'd5);
        if_pc4 = 32'h208;
        tick();
        check("addi_ctrl", idex_ctrl, 8'h03);
        check("addi_imm", idex_imm, 5);
        if_instr = i_ins(6'h04, 9, 0, 16'd2);
        #1;
        check("ba_ready0", id_ready, 0);
        check("ba_taken0", br_taken, 0);
        tick();
        check("ba_bubble", idex_valid, 0);
        check("ba_ready1", id_ready, 1);
        check("ba_taken1", br_taken, 1);
        if_instr = r_ins(9, 9, 8);
        exmem_regwrite = 1'b1;
        exmem_rd = 5'd9;
        exmem_result = 32'h5;
        memwb_regwrite = 1'b1;
        memwb_rd = 5'd9;
        memwb_data = 32'h22;
        tick();
        check("pri_rsval", idex_rs_val, 5);
        check("pri_rtval", idex_rt_val, 5);
        exmem_regwrite = 1'b0;
        memwb_regwrite = 1'b0;
        if_instr = i_ins(6'h04, 9, 0, 16'd2);
        #1;
        check("rt_nohaz", id_ready, 1);
        check("rf_neq", br_taken, 0);
        if_instr = i_ins(6'h04, 8, 0, 16'd2);
        #1;
        check("rd_haz", id_ready, 0);

        if_instr = i_ins(6'h08, 0, 10, 16'd7);
        ex_ready = 1'b0;
        #1;
        check("hold_ready", id_ready, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_valid", idex_valid, 1);
            check("hold_rd", idex_rd, 8);
            check("hold_ctrl", idex_ctrl, 8'h91);
        end
        flush = 1'b1;
        tick();
        check("fl_valid", idex_valid, 0);
        check("fl_ctrl", idex_ctrl, 0);
        flush = 1'b0;
        ex_ready = 1'b1;

        if_instr = i_ins(6'h23, 0, 7, 16'd0);
        tick();
        if_instr = i_ins(6'h04, 7, 6, 16'd1);
        tick();
        check("fc_pre", id_ready, 0);
        flush = 1'b1;
        ex_ready = 1'b0;
        tick();
        flush = 1'b0;
        ex_ready = 1'b1;
        #1;
        check("fc_cleared", id_ready, 1);

        tick();
        if_instr = i_ins(6'h23, 0, 7, 16'd0);
        if_pc4 = 32'h300;
        tick();
        if_instr = i_ins(6'h04, 7, 6, 16'd1);
        tick();
        #2;
        if_instr = j_ins(26'h10);
        rst = 1'b1;
        #1;
        check("mr_valid", idex_valid, 0);
        check("mr_rt", idex_rt, 0);
        check("mr_pc4", idex_pc4, 0);
        check("mr_taken", br_taken, 0);
        if_instr = i_ins(6'h04, 7, 6, 16'd1);
        rst = 1'b0;
        #1;
        check("mr_ready", id_ready, 1);

        if_instr = r_ins(0, 0, 3);
        memwb_regwrite = 1'b1;
        memwb_rd = 5'd0;
        memwb_data = 32'hDEAD;
        tick();
        check("r0_nofwd", idex_rs_val, 0);
        memwb_regwrite = 1'b0;
        if_instr = r_ins(5, 0, 3);
        tick();
        check("rst_r5", idex_rs_val, 0);
        if_instr = r_ins(0, 0, 3);
        tick();
        check("r0_nowrite", idex_rs_val, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
